mem_cache_ctrl_param: RTL and testbench
=======================================

Name: mem_cache_ctrl_param

Overview:
- Parametrised successor to the MEM-stage cache controller: a set-associative (1- or 2-way), write-through, no-write-allocate cache.
- Sits between the MEM stage (driven by MEM_R_EN/MEM_W_EN, ALU result, store value) and the SRAM controller, which returns a full line per read.
- Adds over the previous generation: configurable geometry, LRU replacement, a single-cycle flush, and saturating hit/miss counters.

Parameters:
- DATA_W, 32: word width; byte offset is 2 bits, fixed.
- WORDS_PER_LINE, 2: words per line, power of two; SRAM read bus width is DATA_W*WORDS_PER_LINE.
- SETS, 64: number of sets, power of two.
- WAYS, 2: associativity; only 1 or 2 are legal.
- CNT_W, 16: width of each statistics counter.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous reset, active-low.
- MEM_R_EN  in  1  load request.
- MEM_W_EN  in  1  store request.
- address  in  32  byte address.
- wdata  in  DATA_W  store data.
- flush  in  1  invalidate all lines.
- ready  out  1  access complete; pipeline is frozen while low.
- rdata  out  DATA_W  load data.
- sram_address  out  32  SRAM byte address.
- sram_wdata  out  DATA_W  SRAM store data.
- sram_write  out  1  SRAM write request.
- sram_read  out  1  SRAM line-read request.
- sram_ready  in  1  SRAM access done; valid for one cycle.
- sram_rdata  in  DATA_W*WORDS_PER_LINE  line data; word 0 is in the LSBs.
- hit_count  out  CNT_W  read hits.
- miss_count  out  CNT_W  read misses.

Behaviour:
- Address split:
  - [1:0] byte offset, ignored.
  - Next log2(WORDS_PER_LINE) bits: word select.
  - Next log2(SETS) bits: index.
  - Remaining upper bits: tag.
- Storage per set and way: valid bit, tag, line. One LRU bit per set; it is unused when WAYS=1.
- Reset, asynchronous on rst=0:
  - State=IDLE.
  - All valid bits, LRU bits and both counters cleared to 0.
  - sram_read=0, sram_write=0, sram_address=0, sram_wdata=0.
- ready and rdata are combinational from state and request:
  - With no request in IDLE: ready=1, rdata=0.
- Request holding: the requester holds address, wdata and the enables stable while ready=0.
- Both MEM_R_EN and MEM_W_EN high: treated as a write.
- States:
  - IDLE:
    - Read hit: ready=1 in the same cycle; rdata = selected word of the hitting way; LRU[index] = the other way; hit_count += 1; stay in IDLE.
    - Read miss: ready=0; go to RD_MISS.
    - Write: ready=0; go to WR.
    - flush=1 with no request: all valid bits cleared at the clock edge; ready stays 1.
    - flush together with a request: the request is served first; flush is ignored that cycle.
  - RD_MISS:
    - sram_read=1; sram_address = address with word and byte offset bits zeroed.
    - On sram_ready=1, in the same cycle:
      - ready=1; rdata = selected word of sram_rdata.
      - At the edge: fill the victim way (valid=1, tag, line); LRU[index] = the other way; miss_count += 1; return to IDLE.
    - Victim selection: way0 if invalid, else way1 if invalid, else the LRU way.
  - WR:
    - sram_write=1; sram_address = address; sram_wdata = wdata.
    - On sram_ready=1: ready=1.
    - If the line is present in any valid way, that word is updated at the edge. LRU is not touched.
    - No allocation on a miss. Return to IDLE.
- sram_read and sram_write are never high together, and are never high in IDLE.
- Counters saturate at all-ones and never wrap. Writes are not counted.
- WAYS=1: the victim is always way0.
- Reset mid-miss: the SRAM request is dropped immediately and no fill occurs.

Test Plan:
- Reset, then read 0x400 -> ready=0, sram_read=1, sram_address=0x400. sram_ready with line {0x22,0x11} -> rdata=0x11, ready=1, miss_count=1.
- Read 0x404 immediately after -> ready=1 in the same cycle, rdata=0x22, no sram_read, hit_count=1.
- Read 0x400, 0x600, 0x800 (all index 0), each filled from SRAM -> then read 0x600 hits; read 0x400 misses, because 0x400 was evicted as LRU when 0x800 was filled.
- Write 0x404=0xAB after 0x400 is cached -> sram_write=1, sram_wdata=0xAB, ready on sram_ready. A later read of 0x404 hits with 0xAB. Write to 0xC00 (not cached) -> no fill; a later read of 0xC00 misses.
- flush pulse in IDLE after caching 0x400 -> the next read of 0x400 misses. Assert rst=0 during RD_MISS -> sram_read drops asynchronously, both counters read 0, a later read of 0x400 misses.
- CNT_W=2, five consecutive hits -> hit_count holds 3.

Source files
------------

// File: rtl/mem_cache_ctrl_param.sv
// MEM-stage cache controller: 1- or 2-way set-associative, write-through,
// no-write-allocate, with LRU replacement, single-cycle flush and hit/miss counters.
module mem_cache_ctrl_param #(
   parameter int DATA_W         = 32,
   parameter int WORDS_PER_LINE = 2,
   parameter int SETS           = 64,
   parameter int WAYS           = 2,
   parameter int CNT_W          = 16
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             MEM_R_EN,
   input  logic                             MEM_W_EN,
   input  logic [31:0]                      address,
   input  logic [DATA_W-1:0]                wdata,
   input  logic                             flush,
   output logic                             ready,
   output logic [DATA_W-1:0]                rdata,
   output logic [31:0]                      sram_address,
   output logic [DATA_W-1:0]                sram_wdata,
   output logic                             sram_write,
   output logic                             sram_read,
   input  logic                             sram_ready,
   input  logic [DATA_W*WORDS_PER_LINE-1:0] sram_rdata,
   output logic [CNT_W-1:0]                 hit_count,
   output logic [CNT_W-1:0]                 miss_count
);

   localparam int OFF_W   = $clog2(WORDS_PER_LINE);
   localparam int IDX_W   = $clog2(SETS);
   localparam int SEL_W   = (OFF_W > 0) ? OFF_W : 1;
   localparam int IX_W    = (IDX_W > 0) ? IDX_W : 1;
   localparam int TAG_LSB = 2 + OFF_W + IDX_W;
   localparam int TAG_W   = 32 - TAG_LSB;
   localparam int LINE_W  = DATA_W * WORDS_PER_LINE;
   localparam logic [31:0] LINE_MASK = 32'(WORDS_PER_LINE * 4 - 1);

   typedef enum logic [1:0] {IDLE, RD_MISS, WR} state_t;

   state_t state, next_state;

   logic [SETS-1:0]   valid_q [WAYS];
   logic [SETS-1:0]   lru_q;
   logic [TAG_W-1:0]  tag_mem [WAYS][SETS];
   logic [LINE_W-1:0] line_mem [WAYS][SETS];

   logic [SEL_W-1:0]  word_sel;
   logic [IX_W-1:0]   set_idx;
   logic [TAG_W-1:0]  addr_tag;
   logic [1:0]        set_valid;
   logic [1:0]        set_hit;
   logic [LINE_W-1:0] hit_line;
   logic              is_hit;
   logic              hit_way;
   logic              victim;
   logic              rd_req;
   logic              wr_req;
   logic              hit_evt;
   logic              fill_evt;
   logic              wr_evt;
   logic              flush_evt;

   assign word_sel = SEL_W'((address >> 2) & 32'(WORDS_PER_LINE - 1));
   assign set_idx  = IX_W'((address >> (2 + OFF_W)) & 32'(SETS - 1));
   assign addr_tag = address[31:TAG_LSB];
   assign rd_req   = MEM_R_EN && !MEM_W_EN;
   assign wr_req   = MEM_W_EN;

   // Tag lookup across the ways of the addressed set
   always_comb begin
      set_valid = '0;
      set_hit   = '0;
      hit_line  = '0;
      for (int w = 0; w < WAYS; w++) begin
         set_valid[w] = valid_q[w][set_idx];
         set_hit[w]   = valid_q[w][set_idx] && (tag_mem[w][set_idx] == addr_tag);
         if (set_hit[w]) hit_line = line_mem[w][set_idx];
      end
   end

   assign is_hit  = |set_hit;
   assign hit_way = set_hit[1];

   // Victim: first invalid way, otherwise the least recently used one
   always_comb begin
      victim = 1'b0;
      if (WAYS == 2 && set_valid[0]) begin
         if (!set_valid[1]) victim = 1'b1;
         else               victim = lru_q[set_idx];
      end
   end

   always_comb begin
      next_state   = state;
      ready        = 1'b0;
      rdata        = '0;
      sram_read    = 1'b0;
      sram_write   = 1'b0;
      sram_address = '0;
      sram_wdata   = '0;
      hit_evt      = 1'b0;
      fill_evt     = 1'b0;
      wr_evt       = 1'b0;
      flush_evt    = 1'b0;
      case (state)
         IDLE: begin
            if (wr_req) begin
               next_state = WR;
            end else if (rd_req) begin
               if (is_hit) begin
                  ready   = 1'b1;
                  rdata   = hit_line[word_sel*DATA_W +: DATA_W];
                  hit_evt = 1'b1;
               end else begin
                  next_state = RD_MISS;
               end
            end else begin
               ready     = 1'b1;
               flush_evt = flush;
            end
         end
         RD_MISS: begin
            sram_read    = 1'b1;
            sram_address = address & ~LINE_MASK;
            if (sram_ready) begin
               ready      = 1'b1;
               rdata      = sram_rdata[word_sel*DATA_W +: DATA_W];
               fill_evt   = 1'b1;
               next_state = IDLE;
            end
         end
         WR: begin
            sram_write   = 1'b1;
            sram_address = address;
            sram_wdata   = wdata;
            if (sram_ready) begin
               ready      = 1'b1;
               wr_evt     = 1'b1;
               next_state = IDLE;
            end
         end
         default: next_state = IDLE;
      endcase
   end

   // Control state: FSM, valid/LRU bits and saturating statistics
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         lru_q      <= '0;
         hit_count  <= '0;
         miss_count <= '0;
         for (int w = 0; w < WAYS; w++) valid_q[w] <= '0;
      end else begin
         state <= next_state;
         if (flush_evt) begin
            for (int w = 0; w < WAYS; w++) valid_q[w] <= '0;
         end
         if (fill_evt) begin
            for (int w = 0; w < WAYS; w++) begin
               if (victim == 1'(w)) valid_q[w][set_idx] <= 1'b1;
            end
         end
         if (WAYS == 2 && hit_evt)  lru_q[set_idx] <= ~hit_way;
         if (WAYS == 2 && fill_evt) lru_q[set_idx] <= ~victim;
         if (hit_evt && hit_count != {CNT_W{1'b1}})
            hit_count <= hit_count + CNT_W'(1);
         if (fill_evt && miss_count != {CNT_W{1'b1}})
            miss_count <= miss_count + CNT_W'(1);
      end
   end

   // Tag and line storage carry no reset; validity is tracked by valid_q
   always_ff @(posedge clk) begin
      for (int w = 0; w < WAYS; w++) begin
         if (fill_evt && victim == 1'(w)) begin
            tag_mem[w][set_idx]  <= addr_tag;
            line_mem[w][set_idx] <= sram_rdata;
         end
         if (wr_evt && set_hit[w])
            line_mem[w][set_idx][word_sel*DATA_W +: DATA_W] <= wdata;
      end
   end

endmodule

// File: tb/tb_mem_cache_ctrl_param.sv
// Directed bench for mem_cache_ctrl_param: a vector table covering hits, misses,
// LRU eviction, writes and flush, plus a hand sequence for reset during a miss.
module tb_mem_cache_ctrl_param;

   logic        clk;
   logic        rst;
   logic        MEM_R_EN;
   logic        MEM_W_EN;
   logic [31:0] address;
   logic [31:0] wdata;
   logic        flush;
   logic        sram_ready;
   logic [63:0] sram_rdata;

   logic        ready, s_ready;
   logic [31:0] rdata, s_rdata;
   logic [31:0] sram_address, s_sram_address;
   logic [31:0] sram_wdata, s_sram_wdata;
   logic        sram_write, s_sram_write;
   logic        sram_read, s_sram_read;
   logic [15:0] hit_count, miss_count;
   logic [1:0]  s_hit_count, s_miss_count;

   int tests_run;
   int tests_failed;

   typedef struct {
      logic        r_en;
      logic        w_en;
      logic        flsh;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [63:0] line;
      logic        exp_hit;
      logic [31:0] exp_rdata;
      logic [31:0] exp_sa;
      int          exp_hits;
      int          exp_misses;
   } vec_t;

   vec_t vecs[$];

   mem_cache_ctrl_param dut (
      .clk(clk), .rst(rst), .MEM_R_EN(MEM_R_EN), .MEM_W_EN(MEM_W_EN),
      .address(address), .wdata(wdata), .flush(flush), .ready(ready), .rdata(rdata),
      .sram_address(sram_address), .sram_wdata(sram_wdata), .sram_write(sram_write),
      .sram_read(sram_read), .sram_ready(sram_ready), .sram_rdata(sram_rdata),
      .hit_count(hit_count), .miss_count(miss_count)
   );

   mem_cache_ctrl_param #(.CNT_W(2)) dut_small (
      .clk(clk), .rst(rst), .MEM_R_EN(MEM_R_EN), .MEM_W_EN(MEM_W_EN),
      .address(address), .wdata(wdata), .flush(flush), .ready(s_ready), .rdata(s_rdata),
      .sram_address(s_sram_address), .sram_wdata(s_sram_wdata), .sram_write(s_sram_write),
      .sram_read(s_sram_read), .sram_ready(sram_ready), .sram_rdata(sram_rdata),
      .hit_count(s_hit_count), .miss_count(s_miss_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic vec_t mk(logic r, logic w, logic f, logic [31:0] a, logic [31:0] d,
                               logic [63:0] line, logic h, logic [31:0] rd,
                               logic [31:0] sa, int hits, int misses);
      vec_t v;
      v.r_en = r; v.w_en = w; v.flsh = f; v.addr = a; v.wdata = d; v.line = line;
      v.exp_hit = h; v.exp_rdata = rd; v.exp_sa = sa;
      v.exp_hits = hits; v.exp_misses = misses;
      return v;
   endfunction

   function automatic int sat3(int x);
      return (x > 3) ? 3 : x;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Called just after a falling edge; leaves the bench just after a falling edge
   task automatic applyStimulus(input int idx, input vec_t v);
      string tag;
      tag = $sformatf("v%0d", idx);
      MEM_R_EN = v.r_en;
      MEM_W_EN = v.w_en;
      address  = v.addr;
      wdata    = v.wdata;
      flush    = v.flsh;
      #1;
      if (v.exp_hit) begin
         checkOutput({tag, " ready"}, 32'(ready), 32'd1);
         checkOutput({tag, " rdata"}, rdata, v.exp_rdata);
         checkOutput({tag, " no sram_read"}, 32'(sram_read), 32'd0);
         @(posedge clk);
      end else begin
         checkOutput({tag, " ready low"}, 32'(ready), 32'd0);
         @(negedge clk);
         #1;
         checkOutput({tag, " still waiting"}, 32'(ready), 32'd0);
         checkOutput({tag, " sram_write"}, 32'(sram_write), 32'(v.w_en));
         checkOutput({tag, " sram_read"}, 32'(sram_read), 32'(!v.w_en));
         checkOutput({tag, " sram_address"}, sram_address, v.exp_sa);
         if (v.w_en) checkOutput({tag, " sram_wdata"}, sram_wdata, v.wdata);
         sram_ready = 1'b1;
         sram_rdata = v.line;
         #1;
         checkOutput({tag, " ready on sram_ready"}, 32'(ready), 32'd1);
         if (!v.w_en) checkOutput({tag, " fill rdata"}, rdata, v.exp_rdata);
         @(posedge clk);
      end
      @(negedge clk);
      MEM_R_EN   = 1'b0;
      MEM_W_EN   = 1'b0;
      flush      = 1'b0;
      sram_ready = 1'b0;
      #1;
      checkOutput({tag, " hit_count"}, 32'(hit_count), 32'(v.exp_hits));
      checkOutput({tag, " miss_count"}, 32'(miss_count), 32'(v.exp_misses));
      checkOutput({tag, " small hit_count"}, 32'(s_hit_count), 32'(sat3(v.exp_hits)));
      checkOutput({tag, " small miss_count"}, 32'(s_miss_count), 32'(sat3(v.exp_misses)));
      checkOutput({tag, " sram idle"}, 32'({sram_read, sram_write}), 32'd0);
   endtask

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      rst        = 1'b0;
      MEM_R_EN   = 1'b0;
      MEM_W_EN   = 1'b0;
      address    = '0;
      wdata      = '0;
      flush      = 1'b0;
      sram_ready = 1'b0;
      sram_rdata = '0;

      //       r  w  f  addr        wdata       line                     hit rdata     sram_addr  h  m
      vecs.push_back(mk(1, 0, 0, 32'h400, 32'h0,  64'h00000022_00000011, 0, 32'h11, 32'h400, 0, 1));
      vecs.push_back(mk(1, 0, 0, 32'h404, 32'h0,  64'h0,                 1, 32'h22, 32'h0,   1, 1));
      vecs.push_back(mk(1, 0, 0, 32'h600, 32'h0,  64'h00000036_00000035, 0, 32'h35, 32'h600, 1, 2));
      vecs.push_back(mk(1, 0, 0, 32'h804, 32'h0,  64'h00000048_00000047, 0, 32'h48, 32'h800, 1, 3));
      vecs.push_back(mk(1, 0, 0, 32'h600, 32'h0,  64'h0,                 1, 32'h35, 32'h0,   2, 3));
      vecs.push_back(mk(1, 0, 0, 32'h400, 32'h0,  64'h00000022_00000011, 0, 32'h11, 32'h400, 2, 4));
      vecs.push_back(mk(0, 1, 0, 32'h404, 32'hAB, 64'h0,                 0, 32'h0,  32'h404, 2, 4));
      vecs.push_back(mk(1, 0, 0, 32'h404, 32'h0,  64'h0,                 1, 32'hAB, 32'h0,   3, 4));
      vecs.push_back(mk(1, 0, 0, 32'h400, 32'h0,  64'h0,                 1, 32'h11, 32'h0,   4, 4));
      vecs.push_back(mk(0, 1, 0, 32'hC00, 32'h55, 64'h0,                 0, 32'h0,  32'hC00, 4, 4));
      vecs.push_back(mk(1, 0, 0, 32'hC00, 32'h0,  64'h00000099_00000055, 0, 32'h55, 32'hC00, 4, 5));
      vecs.push_back(mk(1, 0, 0, 32'hC04, 32'h0,  64'h0,                 1, 32'h99, 32'h0,   5, 5));
      vecs.push_back(mk(1, 1, 0, 32'h400, 32'h77, 64'h0,                 0, 32'h0,  32'h400, 5, 5));
      vecs.push_back(mk(1, 0, 0, 32'h400, 32'h0,  64'h0,                 1, 32'h77, 32'h0,   6, 5));
      vecs.push_back(mk(0, 0, 1, 32'h0,   32'h0,  64'h0,                 1, 32'h0,  32'h0,   6, 5));
      vecs.push_back(mk(1, 0, 0, 32'h400, 32'h0,  64'h00000088_00000077, 0, 32'h77, 32'h400, 6, 6));
      vecs.push_back(mk(1, 0, 1, 32'h404, 32'h0,  64'h0,                 1, 32'h88, 32'h0,   7, 6));
      vecs.push_back(mk(1, 0, 0, 32'h400, 32'h0,  64'h0,                 1, 32'h77, 32'h0,   8, 6));
      vecs.push_back(mk(1, 0, 0, 32'h404, 32'h0,  64'h0,                 1, 32'h88, 32'h0,   9, 6));
      vecs.push_back(mk(1, 0, 0, 32'h400, 32'h0,  64'h0,                 1, 32'h77, 32'h0,  10, 6));
      vecs.push_back(mk(1, 0, 0, 32'h404, 32'h0,  64'h0,                 1, 32'h88, 32'h0,  11, 6));

      @(negedge clk);
      @(negedge clk);
      #1;
      checkOutput("reset ready", 32'(ready), 32'd1);
      checkOutput("reset rdata", rdata, 32'd0);
      checkOutput("reset sram_read", 32'(sram_read), 32'd0);
      checkOutput("reset sram_write", 32'(sram_write), 32'd0);
      checkOutput("reset sram_address", sram_address, 32'd0);
      checkOutput("reset sram_wdata", sram_wdata, 32'd0);
      checkOutput("reset hit_count", 32'(hit_count), 32'd0);
      checkOutput("reset miss_count", 32'(miss_count), 32'd0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);

      for (int i = 0; i < vecs.size(); i++) applyStimulus(i, vecs[i]);

      // Asynchronous reset while a line fill is outstanding
      MEM_R_EN = 1'b1;
      address  = 32'h600;
      #1;
      checkOutput("midmiss ready low", 32'(ready), 32'd0);
      @(negedge clk);
      #1;
      checkOutput("midmiss sram_read", 32'(sram_read), 32'd1);
      #1;
      rst = 1'b0;
      #1;
      checkOutput("midmiss sram_read dropped", 32'(sram_read), 32'd0);
      checkOutput("midmiss hit_count", 32'(hit_count), 32'd0);
      checkOutput("midmiss miss_count", 32'(miss_count), 32'd0);
      checkOutput("midmiss small hit_count", 32'(s_hit_count), 32'd0);
      MEM_R_EN = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      applyStimulus(100, mk(1, 0, 0, 32'h400, 32'h0, 64'h00000022_00000011, 0, 32'h11,
                            32'h400, 0, 1));

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
